// File: rtl/ring_admit_arb.sv
// ring_admit_arb: merges loop-back (internal) and external packets onto the
// ring's first stage. It keeps track of ring occupancy, holds back external
// admission near capacity or while draining, and bounds how many times in a
// row the internal path can beat a waiting external request.
module ring_admit_arb #(
    parameter int PKT_W      = 40,
    parameter int RING_CAP   = 16,
    parameter int RESERVE    = 2,
    parameter int STARVE_LIM = 4,
    parameter int CNT_W      = 5
) (
    input  logic             CP,
    input  logic             MR,
    input  logic             Send_in_a,
    input  logic [PKT_W-1:0] PACKET_IN_INTERNAL,
    output logic             Ack_out_a,
    input  logic             Send_in_b,
    input  logic [PKT_W-1:0] PACKET_IN_EXTERNAL,
    output logic             Ack_out_b,
    output logic             Send_out,
    input  logic             Ack_in,
    output logic [PKT_W-1:0] PACKET_OUT,
    input  logic             Copy_inc,
    input  logic             Exit_dec,
    input  logic             Drain,
    output logic             Drain_done,
    output logic [CNT_W-1:0] OCC,
    output logic             Ovf_err
);

    localparam int SC_W = $clog2(STARVE_LIM + 1);
    localparam logic [SC_W-1:0]  STARVE_MAX = SC_W'(STARVE_LIM);
    localparam logic [CNT_W-1:0] ADMIT_LIM  = CNT_W'(RING_CAP - RESERVE);
    localparam logic [CNT_W-1:0] OCC_CAP    = CNT_W'(RING_CAP);
    localparam logic [CNT_W+1:0] OCC_CAP_X  = (CNT_W + 2)'(RING_CAP);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_A = 2'd1,
        BUSY_B = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic               elig_a_s;
    logic               elig_b_s;
    logic               grant_a_s;
    logic               grant_b_s;
    logic               send_out_r;
    logic               send_out_nxt_s;
    logic               ack_a_r;
    logic               ack_b_r;
    logic [PKT_W-1:0]   pkt_r;
    logic [PKT_W-1:0]   pkt_nxt_s;
    logic [CNT_W-1:0]   occ_r;
    logic [CNT_W-1:0]   occ_nxt_s;
    logic [CNT_W+1:0]   occ_sum_s;
    logic [CNT_W+1:0]   occ_exit_s;
    logic [CNT_W+1:0]   occ_diff_s;
    logic               err_r;
    logic               err_nxt_s;
    logic [SC_W-1:0]    starve_r;
    logic [SC_W-1:0]    starve_nxt_s;
    logic               drain_done_r;
    logic               drain_done_nxt_s;

    assign elig_a_s = Send_in_a;
    assign elig_b_s = Send_in_b & ~Drain & (occ_r < ADMIT_LIM);

    // Arbitration: external wins when internal is absent or has starved it long enough.
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (state_r == IDLE) begin
            if (elig_b_s && (!elig_a_s || (starve_r == STARVE_MAX))) begin
                grant_b_s = 1'b1;
            end else if (elig_a_s) begin
                grant_a_s = 1'b1;
            end else begin
                grant_a_s = 1'b0;
                grant_b_s = 1'b0;
            end
        end else begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge CP or posedge MR) begin
        if (MR) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state: a grant opens a transfer, a sampled Ack_in closes it.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_b_s) begin
                    state_nxt_s = BUSY_B;
                end else if (grant_a_s) begin
                    state_nxt_s = BUSY_A;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY_A, BUSY_B: begin
                if (Ack_in) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output next values; registered below so every output comes from a flop.
    always_comb begin
        send_out_nxt_s = 1'b0;
        pkt_nxt_s      = pkt_r;
        case (state_r)
            IDLE: begin
                send_out_nxt_s = grant_a_s | grant_b_s;
                if (grant_b_s) begin
                    pkt_nxt_s = PACKET_IN_EXTERNAL;
                end else if (grant_a_s) begin
                    pkt_nxt_s = PACKET_IN_INTERNAL;
                end else begin
                    pkt_nxt_s = pkt_r;
                end
            end
            BUSY_A, BUSY_B: begin
                send_out_nxt_s = ~Ack_in;
                pkt_nxt_s      = pkt_r;
            end
            default: begin
                send_out_nxt_s = 1'b0;
                pkt_nxt_s      = pkt_r;
            end
        endcase
    end

    // Occupancy: net of admission, duplication and exit, clamped at both ends.
    always_comb begin
        occ_sum_s  = {2'b00, occ_r} + {{(CNT_W + 1){1'b0}}, grant_b_s}
                   + {{(CNT_W + 1){1'b0}}, Copy_inc};
        occ_exit_s = {{(CNT_W + 1){1'b0}}, Exit_dec};
        occ_diff_s = occ_sum_s - occ_exit_s;
        if (occ_sum_s < occ_exit_s) begin
            occ_nxt_s = {CNT_W{1'b0}};
            err_nxt_s = 1'b1;
        end else if (occ_diff_s > OCC_CAP_X) begin
            occ_nxt_s = OCC_CAP;
            err_nxt_s = 1'b1;
        end else begin
            occ_nxt_s = occ_diff_s[CNT_W-1:0];
            err_nxt_s = err_r;
        end
    end

    // Starvation counter: counts internal wins while external was waiting.
    always_comb begin
        if (grant_b_s || !elig_b_s) begin
            starve_nxt_s = {SC_W{1'b0}};
        end else if (grant_a_s && (starve_r != STARVE_MAX)) begin
            starve_nxt_s = starve_r + SC_W'(1'b1);
        end else begin
            starve_nxt_s = starve_r;
        end
    end

    assign drain_done_nxt_s = Drain & (occ_r == {CNT_W{1'b0}}) & (state_r == IDLE) & ~Send_in_a;

    // Registered outputs, occupancy and arbitration history.
    always_ff @(posedge CP or posedge MR) begin
        if (MR) begin
            send_out_r   <= 1'b0;
            ack_a_r      <= 1'b0;
            ack_b_r      <= 1'b0;
            pkt_r        <= {PKT_W{1'b0}};
            occ_r        <= {CNT_W{1'b0}};
            err_r        <= 1'b0;
            starve_r     <= {SC_W{1'b0}};
            drain_done_r <= 1'b0;
        end else begin
            send_out_r   <= send_out_nxt_s;
            ack_a_r      <= grant_a_s;
            ack_b_r      <= grant_b_s;
            pkt_r        <= pkt_nxt_s;
            occ_r        <= occ_nxt_s;
            err_r        <= err_nxt_s;
            starve_r     <= starve_nxt_s;
            drain_done_r <= drain_done_nxt_s;
        end
    end

    assign Send_out   = send_out_r;
    assign Ack_out_a  = ack_a_r;
    assign Ack_out_b  = ack_b_r;
    assign PACKET_OUT = pkt_r;
    assign OCC        = occ_r;
    assign Ovf_err    = err_r;
    assign Drain_done = drain_done_r;

endmodule

// File: tb/tb_ring_admit_arb.sv
// Bench for ring_admit_arb: a behavioural model of the admission rules is
// compared with the DUT on every falling edge, and directed scenarios pin
// the model with hand-computed values.
module tb_ring_admit_arb;

    localparam int PKT_W      = 40;
    localparam int RING_CAP   = 16;
    localparam int RESERVE    = 2;
    localparam int STARVE_LIM = 4;
    localparam int CNT_W      = 5;

    logic             CP = 1'b0;
    logic             MR;
    logic             Send_in_a;
    logic [PKT_W-1:0] PACKET_IN_INTERNAL;
    logic             Ack_out_a;
    logic             Send_in_b;
    logic [PKT_W-1:0] PACKET_IN_EXTERNAL;
    logic             Ack_out_b;
    logic             Send_out;
    logic             Ack_in;
    logic [PKT_W-1:0] PACKET_OUT;
    logic             Copy_inc;
    logic             Exit_dec;
    logic             Drain;
    logic             Drain_done;
    logic [CNT_W-1:0] OCC;
    logic             Ovf_err;

    int n_cmp = 0;
    int n_bad = 0;
    int n_ack_a = 0;
    int n_ack_b = 0;
    byte gq[$];
    logic prev_ack = 1'b0;

    ring_admit_arb #(
        .PKT_W(PKT_W), .RING_CAP(RING_CAP), .RESERVE(RESERVE),
        .STARVE_LIM(STARVE_LIM), .CNT_W(CNT_W)
    ) dut (
        .CP(CP), .MR(MR),
        .Send_in_a(Send_in_a), .PACKET_IN_INTERNAL(PACKET_IN_INTERNAL), .Ack_out_a(Ack_out_a),
        .Send_in_b(Send_in_b), .PACKET_IN_EXTERNAL(PACKET_IN_EXTERNAL), .Ack_out_b(Ack_out_b),
        .Send_out(Send_out), .Ack_in(Ack_in), .PACKET_OUT(PACKET_OUT),
        .Copy_inc(Copy_inc), .Exit_dec(Exit_dec), .Drain(Drain),
        .Drain_done(Drain_done), .OCC(OCC), .Ovf_err(Ovf_err)
    );

    always #5 CP = ~CP;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int               m_owner;   // 0 none, 1 internal, 2 external
    int               m_occ;
    int               m_streak;
    int               m_n;
    int               mg;
    bit               m_ext_ok;
    logic [PKT_W-1:0] m_pkt;
    logic             m_send, m_ack_a, m_ack_b, m_err, m_dd;

    // Model update on each clock edge; reset is immediate.
    always @(posedge CP or posedge MR) begin
        if (MR) begin
            m_owner = 0; m_occ = 0; m_streak = 0; m_pkt = '0;
            m_send = 1'b0; m_ack_a = 1'b0; m_ack_b = 1'b0; m_err = 1'b0; m_dd = 1'b0;
        end else begin
            m_ext_ok = Send_in_b && !Drain && (m_occ < RING_CAP - RESERVE);
            m_dd = Drain && (m_occ == 0) && (m_owner == 0) && !Send_in_a;
            mg = 0;
            if (m_owner == 0) begin
                if (m_ext_ok && (!Send_in_a || m_streak == STARVE_LIM)) mg = 2;
                else if (Send_in_a) mg = 1;
            end else if (Ack_in) begin
                m_owner = 0;
            end
            if (mg != 0) begin
                m_owner = mg;
                m_pkt = (mg == 2) ? PACKET_IN_EXTERNAL : PACKET_IN_INTERNAL;
            end
            m_send  = (m_owner != 0);
            m_ack_a = (mg == 1);
            m_ack_b = (mg == 2);
            m_n = m_occ + ((mg == 2) ? 1 : 0) + (Copy_inc ? 1 : 0) - (Exit_dec ? 1 : 0);
            if (m_n < 0) begin
                m_n = 0; m_err = 1'b1;
            end else if (m_n > RING_CAP) begin
                m_n = RING_CAP; m_err = 1'b1;
            end
            m_occ = m_n;
            if (mg == 2 || !m_ext_ok) m_streak = 0;
            else if (mg == 1 && m_streak < STARVE_LIM) m_streak++;
        end
    end

    // Compare process: every falling edge outside reset.
    always @(negedge CP) begin
        if (!MR) begin
            check("send_out",   Send_out,   m_send);
            check("ack_a",      Ack_out_a,  m_ack_a);
            check("ack_b",      Ack_out_b,  m_ack_b);
            check("packet_out", PACKET_OUT, m_pkt);
            check("occ",        OCC,        m_occ);
            check("ovf_err",    Ovf_err,    m_err);
            check("drain_done", Drain_done, m_dd);
            check("ack_gap",    prev_ack & (Ack_out_a | Ack_out_b), 1'b0);
            if (Ack_out_a) begin n_ack_a++; gq.push_back("A"); end
            if (Ack_out_b) begin n_ack_b++; gq.push_back("B"); end
            prev_ack = Ack_out_a | Ack_out_b;
        end else begin
            prev_ack = 1'b0;
        end
    end

    task automatic reset_dut();
        @(negedge CP);
        Send_in_a = 1'b0; Send_in_b = 1'b0; Ack_in = 1'b0;
        Copy_inc = 1'b0; Exit_dec = 1'b0; Drain = 1'b0;
        PACKET_IN_INTERNAL = 40'hAA; PACKET_IN_EXTERNAL = 40'h55;
        MR = 1'b1;
        repeat (2) @(negedge CP);
        MR = 1'b0;
    endtask

    initial begin
        int base;
        int k;
        bit seen;
        string exp_s;
        MR = 1'b0;
        Send_in_a = 1'b0; Send_in_b = 1'b0; Ack_in = 1'b0;
        Copy_inc = 1'b0; Exit_dec = 1'b0; Drain = 1'b0;
        PACKET_IN_INTERNAL = 40'hAA; PACKET_IN_EXTERNAL = 40'h55;
        #1 MR = 1'b1;
        @(negedge CP);
        check("rst_send_out", Send_out, 1'b0);
        check("rst_occ", OCC, 5'd0);
        check("rst_pkt", PACKET_OUT, 40'h0);
        check("rst_err", Ovf_err, 1'b0);
        check("rst_acks", {Ack_out_a, Ack_out_b, Drain_done}, 3'b000);

        // Starvation bound: four internal wins, then external.
        reset_dut();
        gq.delete();
        seen = 1'b0;
        Send_in_a = 1'b1; Send_in_b = 1'b1; Ack_in = 1'b1;
        repeat (14) begin
            @(negedge CP);
            if (Ack_out_b && !seen) begin
                seen = 1'b1;
                check("t1_ext_pkt", PACKET_OUT, 40'h55);
                check("t1_ext_occ", OCC, 5'd1);
            end
        end
        Send_in_a = 1'b0; Send_in_b = 1'b0;
        exp_s = "AAAABA";
        check("t1_grant_count_ok", gq.size() >= 6, 1'b1);
        for (int i = 0; i < 6; i++) begin
            check("t1_grant_order", (gq.size() > i) ? gq[i] : 8'h00, exp_s[i]);
        end

        // Admission limit at RING_CAP-RESERVE, reopened by one exit.
        reset_dut();
        base = n_ack_b;
        Send_in_b = 1'b1; Ack_in = 1'b1;
        repeat (40) @(negedge CP);
        check("t2_grants14", n_ack_b - base, 14);
        check("t2_occ14", OCC, 5'd14);
        check("t2_held", Send_out, 1'b0);
        Exit_dec = 1'b1;
        @(negedge CP);
        Exit_dec = 1'b0;
        repeat (3) @(negedge CP);
        check("t2_grant_after_exit", n_ack_b - base, 15);
        Send_in_b = 1'b0;

        // Simultaneous +1/+1/-1 at OCC=5.
        reset_dut();
        Send_in_b = 1'b1; Ack_in = 1'b1;
        k = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge CP);
            if (Ack_out_b) k++;
            if (k == 5) break;
        end
        check("t3_occ5", OCC, 5'd5);
        @(negedge CP);
        Copy_inc = 1'b1; Exit_dec = 1'b1;
        @(negedge CP);
        Copy_inc = 1'b0; Exit_dec = 1'b0;
        check("t3_grant", Ack_out_b, 1'b1);
        check("t3_occ6", OCC, 5'd6);
        Send_in_b = 1'b0;

        // Underflow is sticky until reset.
        reset_dut();
        Exit_dec = 1'b1;
        @(negedge CP);
        Exit_dec = 1'b0;
        check("t3_uf_occ", OCC, 5'd0);
        check("t3_uf_err", Ovf_err, 1'b1);
        repeat (4) @(negedge CP);
        Copy_inc = 1'b1;
        @(negedge CP);
        Copy_inc = 1'b0;
        check("t3_uf_sticky", Ovf_err, 1'b1);
        reset_dut();
        @(negedge CP);
        check("t3_err_cleared", Ovf_err, 1'b0);

        // Overflow clamps at RING_CAP.
        Copy_inc = 1'b1;
        repeat (17) @(negedge CP);
        Copy_inc = 1'b0;
        check("t3_ovf_occ", OCC, 5'd16);
        check("t3_ovf_err", Ovf_err, 1'b1);

        // Drain blocks external admission and reports empty ring.
        reset_dut();
        Copy_inc = 1'b1;
        repeat (3) @(negedge CP);
        Copy_inc = 1'b0;
        Drain = 1'b1; Send_in_b = 1'b1;
        base = n_ack_b;
        repeat (5) @(negedge CP);
        check("t4_no_ext", n_ack_b - base, 0);
        check("t4_dd_low", Drain_done, 1'b0);
        Exit_dec = 1'b1;
        repeat (3) @(negedge CP);
        Exit_dec = 1'b0;
        check("t4_occ0", OCC, 5'd0);
        check("t4_dd_not_yet", Drain_done, 1'b0);
        @(negedge CP);
        check("t4_dd_high", Drain_done, 1'b1);
        // Drain raised during an external transfer does not abort it.
        Drain = 1'b0;
        @(negedge CP);
        check("t4_ext_granted", Ack_out_b, 1'b1);
        Drain = 1'b1; Send_in_b = 1'b0;
        repeat (3) @(negedge CP);
        check("t4_inflight_hold", Send_out, 1'b1);
        Ack_in = 1'b1;
        @(negedge CP);
        check("t4_inflight_done", Send_out, 1'b0);
        Drain = 1'b0; Ack_in = 1'b0;

        // Async reset mid-transfer, then immediate grant of a pending request.
        reset_dut();
        Send_in_a = 1'b1;
        @(negedge CP);
        check("t5_busy_a", Send_out, 1'b1);
        check("t5_pkt_a", PACKET_OUT, 40'hAA);
        #2;
        Send_in_a = 1'b0; Send_in_b = 1'b1;
        MR = 1'b1;
        #1;
        check("t5_async_send", Send_out, 1'b0);
        check("t5_async_pkt", PACKET_OUT, 40'h0);
        @(negedge CP);
        MR = 1'b0;
        @(negedge CP);
        check("t5_first_grant", Ack_out_b, 1'b1);
        check("t5_first_pkt", PACKET_OUT, 40'h55);
        Send_in_b = 1'b0; Ack_in = 1'b1;

        // Ack_in held high: one transfer every two cycles.
        reset_dut();
        Send_in_a = 1'b1; Send_in_b = 1'b1; Ack_in = 1'b1;
        base = n_ack_a + n_ack_b;
        repeat (20) @(negedge CP);
        check("t6_rate", (n_ack_a + n_ack_b) - base, 10);
        Send_in_a = 1'b0; Send_in_b = 1'b0; Ack_in = 1'b0;
        repeat (3) @(negedge CP);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ring_admit_arb.md
RING_ADMIT_ARB -- requirements
Module: ring_admit_arb

Interface
REQ-001 Parameters SHALL be: PKT_W, default 40, packet width. RING_CAP, default 16, maximum packets in the ring. RESERVE, default 2, slots kept free for internal traffic. STARVE_LIM, default 4, maximum consecutive internal wins over an eligible external request. CNT_W, default 5, occupancy counter width.
REQ-002 CP  input  1  clock; all state SHALL change on the rising edge.
REQ-003 MR  input  1  reset; asynchronous, active-high.
REQ-004 Send_in_a  input  1  request from the internal loop-back path.
REQ-005 PACKET_IN_INTERNAL  input  PKT_W  loop-back packet; stable while Send_in_a is high.
REQ-006 Ack_out_a  output  1  one-cycle acceptance pulse to the internal requester.
REQ-007 Send_in_b  input  1  request from the external input.
REQ-008 PACKET_IN_EXTERNAL  input  PKT_W  external packet; stable while Send_in_b is high.
REQ-009 Ack_out_b  output  1  one-cycle acceptance pulse to the external requester.
REQ-010 Send_out  output  1  packet valid toward the ring's first stage.
REQ-011 Ack_in  input  1  downstream acceptance of PACKET_OUT.
REQ-012 PACKET_OUT  output  PKT_W  registered merged packet.
REQ-013 Copy_inc  input  1  one-cycle pulse: the copy stage duplicated a packet (+1 occupancy).
REQ-014 Exit_dec  input  1  one-cycle pulse: a packet left the ring at the output (-1 occupancy).
REQ-015 Drain  input  1  level; blocks external admission while high.
REQ-016 Drain_done  output  1  registered; ring empty under Drain.
REQ-017 OCC  output  CNT_W  current ring occupancy.
REQ-018 Ovf_err  output  1  sticky occupancy under/overflow flag.

Function
REQ-019 The FSM SHALL have three states: IDLE, BUSY_A, BUSY_B.
REQ-020 Internal eligibility SHALL be Send_in_a=1; external eligibility SHALL be Send_in_b=1 and Drain=0 and OCC < RING_CAP-RESERVE.
REQ-021 In IDLE, the arbiter SHALL grant external if it is eligible and either internal is not eligible or starve_cnt=STARVE_LIM; otherwise it SHALL grant internal if eligible.
REQ-022 On a grant edge: PACKET_OUT SHALL load the selected input, Send_out SHALL go to 1, the matching Ack_out_x SHALL pulse high for exactly one cycle, and the FSM SHALL go to BUSY_A or BUSY_B.
REQ-023 In BUSY_x, PACKET_OUT and Send_out SHALL hold until the edge at which Ack_in=1 is sampled; at that edge Send_out SHALL go to 0 and the FSM SHALL return to IDLE.
REQ-024 No grant SHALL occur on the edge that leaves BUSY_x, giving a minimum of 2 cycles per packet.
REQ-025 Ack_in SHALL be ignored in IDLE; Send_in_a and Send_in_b SHALL be ignored in BUSY states.
REQ-026 OCC SHALL update by the net of: +1 (external grant), +1 (Copy_inc), -1 (Exit_dec), all applied in the same cycle (net range -1..+2).
REQ-027 On underflow, OCC SHALL stay at 0 and Ovf_err SHALL be set; on a result above RING_CAP, OCC SHALL clamp to RING_CAP and Ovf_err SHALL be set.
REQ-028 Ovf_err SHALL clear only on MR.
REQ-029 starve_cnt SHALL increment, saturating at STARVE_LIM, on an internal grant while external was eligible.
REQ-030 starve_cnt SHALL clear on an external grant or on any cycle with external not eligible.
REQ-031 Drain_done SHALL be registered from Drain=1 and OCC=0 and state=IDLE and Send_in_a=0; it SHALL fall the cycle after any term fails.
REQ-032 Drain asserted mid-BUSY_B SHALL NOT abort the in-flight transfer.

Reset
REQ-033 When MR=1, the block SHALL immediately and asynchronously force: state IDLE, Send_out=0, Ack_out_a=0, Ack_out_b=0, PACKET_OUT=0, OCC=0, starve_cnt=0, Ovf_err=0, Drain_done=0.
REQ-034 Reset mid-transfer SHALL drop Send_out without waiting for Ack_in; the first grant SHALL be possible on the first edge after MR falls.

Verification
REQ-035 Both requests high, internal packet 0xAA, external packet 0x55, OCC=0, Ack_in returned 1 cycle after each Send_out -> internal granted 4 consecutive times, then external granted once (PACKET_OUT=0x55, OCC=1), then starve_cnt=0.
REQ-036 External-only requests with Ack_in always 1 and no Exit_dec -> 14 grants, OCC reaches 14, Send_in_b then held unacknowledged; one Exit_dec pulse -> next external grant occurs.
REQ-037 Copy_inc and Exit_dec pulsed on the same edge as an external grant at OCC=5 -> OCC=6; Exit_dec alone at OCC=0 -> OCC=0 and Ovf_err=1 until MR.
REQ-038 Drain=1 with OCC=3 and external pending -> no Ack_out_b; three Exit_dec pulses -> Drain_done=1 on the edge after OCC reaches 0.
REQ-039 MR pulsed in BUSY_A with Ack_in low -> Send_out=0 and PACKET_OUT=0 without a clock edge; a pending Send_in_b is granted on the first edge after MR falls.
REQ-040 Ack_in held high continuously -> exactly one transfer per 2 cycles, and Ack_out_x is never high for 2 consecutive cycles.
